control_sequencer: RTL and testbench

- Microcoded fetch/decode/execute controller for the 8-bit CPU.
- Drives the program counter's count-enable and jump inputs, and all other bus/register control lines, as a 16-bit control word.
- Consumes the 4-bit opcode from the instruction register and the carry/zero flags from the flags register.
- Steps through fixed T-states per instruction, supports free-run and single-step operation, and latches a halt state on HLT.

---
 rtl/cpu_ctrl_pkg.sv | 54 +++++
 rtl/control_sequencer_microcode_rom.sv | 58 +++++
 rtl/control_sequencer.sv | 78 +++++++
 tb/tb_control_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the 8-bit CPU control sequencer.
//   - opcode_e      : 4-bit instruction opcodes (IR high nibble)
//   - CTRL_*        : bit positions inside the 16-bit control word
//   - seq_state_e   : sequencer RUN/HALTED state encoding
//   - NUM_STEPS     : T-states per instruction
//   - ctrl_bit()    : one-hot control word with a single line asserted
package cpu_ctrl_pkg;

  localparam int unsigned NUM_STEPS = 5;
  localparam int unsigned OPCODE_W  = 4;
  localparam int unsigned CTRL_W    = 16;
  localparam int unsigned STEP_W    = 3;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  localparam int unsigned CTRL_HLT = 15;
  localparam int unsigned CTRL_MI  = 14;
  localparam int unsigned CTRL_RI  = 13;
  localparam int unsigned CTRL_RO  = 12;
  localparam int unsigned CTRL_IO  = 11;
  localparam int unsigned CTRL_II  = 10;
  localparam int unsigned CTRL_AI  = 9;
  localparam int unsigned CTRL_AO  = 8;
  localparam int unsigned CTRL_EO  = 7;
  localparam int unsigned CTRL_SU  = 6;
  localparam int unsigned CTRL_BI  = 5;
  localparam int unsigned CTRL_OI  = 4;
  localparam int unsigned CTRL_CE  = 3;
  localparam int unsigned CTRL_CO  = 2;
  localparam int unsigned CTRL_J   = 1;
  localparam int unsigned CTRL_FI  = 0;

  typedef enum logic {
    SEQ_RUN    = 1'b0,
    SEQ_HALTED = 1'b1
  } seq_state_e;

  function automatic logic [CTRL_W-1:0] ctrl_bit(input int unsigned idx);
    ctrl_bit = {{(CTRL_W-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/control_sequencer_microcode_rom.sv
// Combinational microcode ROM for the 8-bit CPU.
// Ports:
//   step   in  3   current T-state (0..4)
//   opcode in  4   instruction register high nibble
//   carry  in  1   registered carry flag (used by JC at T2)
//   zero   in  1   registered zero flag (used by JZ at T2)
//   word   out 16  raw control word for this step/opcode/flags
// T0/T1 are the common fetch and ignore the opcode; unused opcodes
// execute as NOP.
module microcode_rom
  import cpu_ctrl_pkg::*;
(
  input  logic [STEP_W-1:0]   step,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                carry,
  input  logic                zero,
  output logic [CTRL_W-1:0]   word
);

  always_comb begin
    word = '0;
    case (step)
      3'd0: word = ctrl_bit(CTRL_CO) | ctrl_bit(CTRL_MI);
      3'd1: word = ctrl_bit(CTRL_RO) | ctrl_bit(CTRL_II) | ctrl_bit(CTRL_CE);
      3'd2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA:
            word = ctrl_bit(CTRL_IO) | ctrl_bit(CTRL_MI);
          OP_LDI: word = ctrl_bit(CTRL_IO) | ctrl_bit(CTRL_AI);
          OP_JMP: word = ctrl_bit(CTRL_IO) | ctrl_bit(CTRL_J);
          OP_JC:  word = carry ? (ctrl_bit(CTRL_IO) | ctrl_bit(CTRL_J)) : '0;
          OP_JZ:  word = zero  ? (ctrl_bit(CTRL_IO) | ctrl_bit(CTRL_J)) : '0;
          OP_OUT: word = ctrl_bit(CTRL_AO) | ctrl_bit(CTRL_OI);
          OP_HLT: word = ctrl_bit(CTRL_HLT);
          default: word = '0;
        endcase
      end
      3'd3: begin
        case (opcode)
          OP_LDA:         word = ctrl_bit(CTRL_RO) | ctrl_bit(CTRL_AI);
          OP_ADD, OP_SUB: word = ctrl_bit(CTRL_RO) | ctrl_bit(CTRL_BI);
          OP_STA:         word = ctrl_bit(CTRL_AO) | ctrl_bit(CTRL_RI);
          default:        word = '0;
        endcase
      end
      3'd4: begin
        case (opcode)
          OP_ADD:  word = ctrl_bit(CTRL_EO) | ctrl_bit(CTRL_AI) | ctrl_bit(CTRL_FI);
          OP_SUB:  word = ctrl_bit(CTRL_EO) | ctrl_bit(CTRL_AI) | ctrl_bit(CTRL_SU)
                        | ctrl_bit(CTRL_FI);
          default: word = '0;
        endcase
      end
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute control sequencer for the 8-bit CPU.
// Ports:
//   clk         in  1   rising-edge clock
//   rst         in  1   asynchronous active-low reset
//   run_mode    in  1   1 = free-run, 0 = single-step
//   step_req    in  1   synchronised step pulse (single-step mode)
//   opcode      in  4   instruction register high nibble
//   carry_flag  in  1   registered carry flag
//   zero_flag   in  1   registered zero flag
//   ctrl        out 16  control word (HLT MI RI RO IO II AI AO EO SU BI OI CE CO J FI)
//   pc_count_en out 1   ctrl[CE], PC count enable
//   pc_jump     out 1   ctrl[J], PC jump
//   step        out 3   current T-state
//   halted      out 1   high while halted
// The control word is gated by advance so a stalled single-step cycle
// has no side effects; downstream registers act on the edge that
// advances the step.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned NUM_STEPS = cpu_ctrl_pkg::NUM_STEPS,
  parameter int unsigned OPCODE_W  = cpu_ctrl_pkg::OPCODE_W,
  parameter int unsigned CTRL_W    = cpu_ctrl_pkg::CTRL_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run_mode,
  input  logic                step_req,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                carry_flag,
  input  logic                zero_flag,
  output logic [CTRL_W-1:0]   ctrl,
  output logic                pc_count_en,
  output logic                pc_jump,
  output logic [2:0]          step,
  output logic                halted
);

  seq_state_e          state_q;
  logic [STEP_W-1:0]   step_q;
  logic [CTRL_W-1:0]   rom_word;
  logic                advance;
  logic                last_step;

  microcode_rom u_rom (
    .step   (step_q),
    .opcode (opcode),
    .carry  (carry_flag),
    .zero   (zero_flag),
    .word   (rom_word)
  );

  // rst is folded in so the control word reads zero for the whole time
  // reset is held, not just after the first edge.
  assign advance   = rst && (state_q == SEQ_RUN) && (run_mode || step_req);
  assign last_step = (step_q == STEP_W'(NUM_STEPS - 1));

  assign ctrl        = advance ? rom_word : '0;
  assign pc_count_en = ctrl[CTRL_CE];
  assign pc_jump     = ctrl[CTRL_J];
  assign step        = step_q;
  assign halted      = (state_q == SEQ_HALTED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SEQ_RUN;
      step_q  <= '0;
    end else if (advance) begin
      if (rom_word[CTRL_HLT]) begin
        state_q <= SEQ_HALTED;
        step_q  <= '0;
      end else begin
        step_q  <= last_step ? '0 : step_q + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  localparam logic [15:0] B_HLT = 16'h8000, B_MI = 16'h4000, B_RI = 16'h2000,
                          B_RO  = 16'h1000, B_IO = 16'h0800, B_II = 16'h0400,
                          B_AI  = 16'h0200, B_AO = 16'h0100, B_EO = 16'h0080,
                          B_SU  = 16'h0040, B_BI = 16'h0020, B_OI = 16'h0010,
                          B_CE  = 16'h0008, B_CO = 16'h0004, B_J  = 16'h0002,
                          B_FI  = 16'h0001;

  logic        clk = 1'b0;
  logic        rst;
  logic        run_mode, step_req, carry_flag, zero_flag;
  logic [3:0]  opcode;
  logic [15:0] ctrl;
  logic        pc_count_en, pc_jump, halted;
  logic [2:0]  step;

  int errors = 0;
  int checks = 0;

  // reference model: instruction T-state counter and halt latch
  int          m_step;
  bit          m_halt;
  bit          m_adv;
  logic [15:0] m_exp;
  logic [15:0] exec_tbl [16][3];

  always #5 clk = ~clk;

  control_sequencer #(.NUM_STEPS(5), .OPCODE_W(4), .CTRL_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .run_mode    (run_mode),
    .step_req    (step_req),
    .opcode      (opcode),
    .carry_flag  (carry_flag),
    .zero_flag   (zero_flag),
    .ctrl        (ctrl),
    .pc_count_en (pc_count_en),
    .pc_jump     (pc_jump),
    .step        (step),
    .halted      (halted)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_word(input int t, input int op, input bit c, input bit z);
    if (t == 0) return B_CO | B_MI;
    if (t == 1) return B_RO | B_II | B_CE;
    if (t == 2 && op == 7 && !c) return 16'h0000;
    if (t == 2 && op == 8 && !z) return 16'h0000;
    return exec_tbl[op][t-2];
  endfunction

  // apply inputs, then check every output against the model
  task automatic drive(input bit run, input bit req, input logic [3:0] op,
                       input bit c, input bit z);
    run_mode = run; step_req = req; opcode = op; carry_flag = c; zero_flag = z;
    m_adv = !m_halt && (run || req);
    m_exp = m_adv ? ref_word(m_step, int'(op), c, z) : 16'h0000;
    #2;
    check_eq("ctrl", ctrl, m_exp);
    check_eq("step", step, m_step);
    check_eq("halted", halted, m_halt);
    check_eq("pc_count_en", pc_count_en, m_exp[3]);
    check_eq("pc_jump", pc_jump, m_exp[1]);
    check_eq("ce_j_excl", ctrl[3] & ctrl[1], 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (m_adv) begin
      if (m_exp[15]) begin
        m_halt = 1'b1;
        m_step = 0;
      end else begin
        m_step = (m_step + 1) % 5;
      end
    end
  endtask

  // assert reset between edges, hold over one edge, release after the next
  task automatic assert_reset();
    rst = 1'b0;
    #1;
    check_eq("rst_step", step, 0);
    check_eq("rst_ctrl", ctrl, 0);
    check_eq("rst_halted", halted, 0);
    @(posedge clk);
    #1;
    check_eq("rst_hold_ctrl", ctrl, 0);
    check_eq("rst_hold_step", step, 0);
    rst = 1'b1;
    m_step = 0;
    m_halt = 1'b0;
  endtask

  task automatic run_instr(input logic [3:0] op, input bit c, input bit z);
    for (int t = 0; t < 5; t++) begin
      drive(1'b1, 1'b0, op, c, z);
      tick();
    end
  endtask

  initial begin
    for (int o = 0; o < 16; o++)
      for (int k = 0; k < 3; k++) exec_tbl[o][k] = 16'h0000;
    exec_tbl[1]  = '{B_IO | B_MI, B_RO | B_AI, 16'h0000};
    exec_tbl[2]  = '{B_IO | B_MI, B_RO | B_BI, B_EO | B_AI | B_FI};
    exec_tbl[3]  = '{B_IO | B_MI, B_RO | B_BI, B_EO | B_AI | B_SU | B_FI};
    exec_tbl[4]  = '{B_IO | B_MI, B_AO | B_RI, 16'h0000};
    exec_tbl[5]  = '{B_IO | B_AI, 16'h0000, 16'h0000};
    exec_tbl[6]  = '{B_IO | B_J, 16'h0000, 16'h0000};
    exec_tbl[7]  = '{B_IO | B_J, 16'h0000, 16'h0000};
    exec_tbl[8]  = '{B_IO | B_J, 16'h0000, 16'h0000};
    exec_tbl[14] = '{B_AO | B_OI, 16'h0000, 16'h0000};
    exec_tbl[15] = '{B_HLT, 16'h0000, 16'h0000};

    rst = 1'b0; run_mode = 1'b1; step_req = 1'b1; opcode = 4'h5;
    carry_flag = 1'b0; zero_flag = 1'b0;
    m_step = 0; m_halt = 1'b0;
    #7;
    assert_reset();

    // LDI free-run
    drive(1, 0, 4'h5, 0, 0); check_eq("ldi_t0", ctrl, 16'h4004); tick();
    drive(1, 0, 4'h5, 0, 0); check_eq("ldi_t1", ctrl, 16'h1408); tick();
    drive(1, 0, 4'h5, 0, 0); check_eq("ldi_t2", ctrl, 16'h0A00); tick();
    drive(1, 0, 4'h5, 0, 0); check_eq("ldi_t3", ctrl, 16'h0000); tick();
    drive(1, 0, 4'h5, 0, 0); check_eq("ldi_t4", ctrl, 16'h0000); tick();
    drive(1, 0, 4'h5, 0, 0); check_eq("ldi_wrap", step, 0); tick();
    run_instr(4'h5, 0, 0);  // finish the wrapped instruction partially shifted
    while (m_step != 0) begin drive(1, 0, 4'h0, 0, 0); tick(); end

    // ADD single-step with 3-cycle gaps
    for (int t = 0; t < 5; t++) begin
      drive(0, 1, 4'h2, 0, 0);
      check_eq("add_step", step, t);
      if (t == 4) check_eq("add_t4", ctrl, 16'h0281);
      tick();
      for (int g = 0; g < 3; g++) begin
        drive(0, 0, 4'h2, 1, 1);
        check_eq("add_gap_ctrl", ctrl, 0);
        tick();
      end
    end

    // JC not taken, then taken
    for (int c = 0; c < 2; c++) begin
      for (int t = 0; t < 5; t++) begin
        drive(1, 0, 4'h7, c[0], 0);
        check_eq("jc_ce", pc_count_en, t == 1);
        if (t == 2) begin
          check_eq("jc_ctrl", ctrl, c ? 16'h0802 : 16'h0000);
          check_eq("jc_jump", pc_jump, c[0]);
        end
        tick();
      end
    end

    // HLT
    drive(1, 0, 4'hF, 0, 0); tick();
    drive(1, 0, 4'hF, 0, 0); tick();
    drive(1, 0, 4'hF, 0, 0); check_eq("hlt_t2", ctrl, 16'h8000); tick();
    for (int i = 0; i < 20; i++) begin
      drive($urandom_range(0, 1), i[0], 4'($urandom_range(0, 15)), 1, 1);
      check_eq("halt_hold", {halted, step, ctrl}, {1'b1, 3'd0, 16'h0000});
      tick();
    end
    assert_reset();
    drive(1, 0, 4'h0, 0, 0); check_eq("post_halt_fetch", ctrl, 16'h4004); tick();
    while (m_step != 0) begin drive(1, 0, 4'h0, 0, 0); tick(); end

    // async reset mid-T3 of SUB
    for (int t = 0; t < 3; t++) begin drive(1, 0, 4'h3, 0, 0); tick(); end
    drive(1, 0, 4'h3, 0, 0);
    check_eq("sub_t3", ctrl, 16'h1020);
    assert_reset();
    drive(1, 0, 4'h3, 0, 0); check_eq("sub_refetch", ctrl, 16'h4004); tick();
    while (m_step != 0) begin drive(1, 0, 4'h0, 0, 0); tick(); end

    // unused opcode 1011
    for (int t = 0; t < 5; t++) begin
      drive(1, 0, 4'hB, 1, 1);
      if (t >= 2) check_eq("op_b_ctrl", ctrl, 0);
      tick();
    end

    // randomized traffic
    begin
      int hc = 0;
      for (int i = 0; i < 600; i++) begin
        drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
              4'($urandom_range(0, 15)), $urandom_range(0, 1) != 0,
              $urandom_range(0, 1) != 0);
        if (m_halt) hc++;
        if (m_halt && hc > 6) begin
          assert_reset();
          hc = 0;
        end else begin
          tick();
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
